// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM states, the default idle byte,
// status bit positions and the sck edge selection helpers.
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

  // Bit positions of the status flags inside the status vector.
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_W        = 4;

  // The leading edge leaves the idle level: rising when sck idles low.
  function automatic logic lead_is_rise(input logic polarity);
    return ~polarity;
  endfunction

  // With PHASE = 0 mosi is sampled on the leading edge, otherwise on the trailing one.
  function automatic logic sample_on_lead(input logic phase);
    return ~phase;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a history
// flop that yields single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronise the pin and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
      prev_p2 <= IDLE;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;
  assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_peripheral.sv
// SPI responder: oversamples sck/ss/mosi in the system clock domain, shifts
// bytes MSB first and exposes tx holding / rx data registers with status flags.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter logic       POLARITY  = 1'b1,
  parameter logic       PHASE     = 1'b0,
  parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] spi_di,
  input  logic       rd,
  output logic [7:0] spi_do,
  output logic       rx_valid,
  output logic       overrun,
  output logic       tx_empty,
  output logic       busy,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  localparam logic LEAD_RISE = lead_is_rise(POLARITY);
  localparam logic SAMP_LEAD = sample_on_lead(PHASE);

  state_e            state;
  state_e            state_next;
  logic              ss_fall, ss_rise, sck_rise, sck_fall, mosi_level;
  logic              ss_level_unused, sck_level_unused;
  logic [1:0]        mosi_edge_unused;
  logic              lead, trail, samp_edge, out_edge;
  logic              load, sample, complete, shift_out, abort;
  logic [2:0]        bit_cnt;
  logic [7:0]        tx_shift, rx_shift, hold, load_byte, rx_next;
  logic              rx_valid_q, overrun_q, tx_empty_q;
  logic [STAT_W-1:0] status;

  spi_sync_edge #(.IDLE(POLARITY)) u_sync_sck (
    .clk(clk), .reset(reset), .din(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.IDLE(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(spi_ss),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.IDLE(1'b1)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .level(mosi_level), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
  );

  assign lead      = LEAD_RISE ? sck_rise : sck_fall;
  assign trail     = LEAD_RISE ? sck_fall : sck_rise;
  assign samp_edge = SAMP_LEAD ? lead : trail;
  assign out_edge  = SAMP_LEAD ? trail : lead;

  assign load_byte = tx_empty_q ? IDLE_BYTE : hold;
  assign rx_next   = {rx_shift[6:0], mosi_level};

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle datapath strobes; ss rising wins over any sck edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sample     = 1'b0;
    complete   = 1'b0;
    shift_out  = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next = ST_SHIFT;
          load       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end else begin
          if (samp_edge) begin
            sample = 1'b1;
            if (bit_cnt == 3'd7) begin
              complete = 1'b1;
              load     = 1'b1;
            end
          end
          if (out_edge) shift_out = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit counter, receive shifter and received-byte flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      spi_do     <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (abort) begin
        bit_cnt <= 3'd0;
      end else if (sample) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_next;
      end
      if (complete) begin
        spi_do     <= rx_next;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rd) overrun_q <= 1'b1;
      end else if (rd) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
    end
  end

  // Holding register, transmit shifter and miso. With PHASE = 0 bit 7 is
  // presented at load, so the trailing edge right after a reload (count 0)
  // must not shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= 8'h00;
      tx_empty_q <= 1'b1;
      tx_shift   <= 8'h00;
      spi_miso   <= 1'b1;
    end else begin
      if (load) tx_empty_q <= 1'b1;
      if (we) begin
        hold       <= spi_di;
        tx_empty_q <= 1'b0;
      end
      if (abort) begin
        spi_miso <= 1'b1;
      end else if (load) begin
        tx_shift <= load_byte;
        if (!PHASE) spi_miso <= load_byte[7];
      end else if (shift_out) begin
        if (PHASE) begin
          spi_miso <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end else if (bit_cnt != 3'd0) begin
          spi_miso <= tx_shift[6];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  // Gather the flags in their fixed positions.
  always_comb begin
    status                = '0;
    status[STAT_RX_VALID] = rx_valid_q;
    status[STAT_TX_EMPTY] = tx_empty_q;
    status[STAT_BUSY]     = (state == ST_SHIFT);
    status[STAT_OVERRUN]  = overrun_q;
  end

  assign rx_valid    = status[STAT_RX_VALID];
  assign tx_empty    = status[STAT_TX_EMPTY];
  assign busy        = status[STAT_BUSY];
  assign overrun     = status[STAT_OVERRUN];
  assign spi_miso_oe = status[STAT_BUSY];

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a PHASE=0 and a PHASE=1 instance share the SPI
// pins; a behavioural master drives them at clk/8 and received bytes are
// checked against a queue of expected values.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] spi_di = 8'h00;
  logic       spi_sck = 1'b1;
  logic       spi_ss = 1'b1;
  logic       spi_mosi = 1'b1;

  logic [7:0] do0, do1;
  logic       rxv0, rxv1, ovr0, ovr1, txe0, txe1, busy0, busy1;
  logic       miso0, miso1, oe0, oe1;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  spi_peripheral #(.POLARITY(1'b1), .PHASE(1'b0), .IDLE_BYTE(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .we(we), .spi_di(spi_di), .rd(rd),
    .spi_do(do0), .rx_valid(rxv0), .overrun(ovr0), .tx_empty(txe0), .busy(busy0),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0)
  );

  spi_peripheral #(.POLARITY(1'b1), .PHASE(1'b1), .IDLE_BYTE(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .we(we), .spi_di(spi_di), .rd(rd),
    .spi_do(do1), .rx_valid(rxv1), .overrun(ovr1), .tx_empty(txe1), .busy(busy1),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    spi_di = b; we = 1'b1;
    wait_clk(1);
    we = 1'b0;
  endtask

  task automatic cpu_read();
    rd = 1'b1;
    wait_clk(1);
    rd = 1'b0;
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    wait_clk(4);
    spi_ss = 1'b1;
    wait_clk(6);
  endtask

  // Master shifting nbits of tx (MSB first), capturing miso; sck idles high.
  task automatic xfer_byte(input bit ph, input logic [7:0] tx, input int nbits,
                           input bit rd_last, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!ph) begin
        spi_mosi = tx[7-i];
        wait_clk(4);
        rx = {rx[6:0], miso0};
        spi_sck = 1'b0;
        if (rd_last && i == nbits - 1) begin
          wait_clk(2); rd = 1'b1; wait_clk(1); rd = 1'b0; wait_clk(1);
        end else begin
          wait_clk(4);
        end
        spi_sck = 1'b1;
      end else begin
        spi_sck = 1'b0;
        spi_mosi = tx[7-i];
        wait_clk(4);
        rx = {rx[6:0], miso1};
        spi_sck = 1'b1;
        wait_clk(4);
      end
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_checks++;
    if ({do0, rxv0, ovr0, txe0, busy0, miso0, oe0} !== {8'h00, 6'b001010})
      $display("FAIL reset_dut0: got %h want %h", {do0, rxv0, ovr0, txe0, busy0, miso0, oe0}, {8'h00, 6'b001010});
    else n_pass++;
    n_checks++;
    if ({do1, rxv1, ovr1, txe1, busy1, miso1, oe1} !== {8'h00, 6'b001010})
      $display("FAIL reset_dut1: got %h want %h", {do1, rxv1, ovr1, txe1, busy1, miso1, oe1}, {8'h00, 6'b001010});
    else n_pass++;
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_basic();
    logic [7:0] rx, exp;
    cpu_write(8'hA5);
    n_checks++;
    if (txe0 !== 1'b0) $display("FAIL basic_tx_full: got %b want 0", txe0); else n_pass++;
    rx_q.push_back(8'h3C);
    ss_begin();
    n_checks++;
    if ({txe0, busy0, oe0} !== 3'b111) $display("FAIL basic_after_ss: got %b want 111", {txe0, busy0, oe0}); else n_pass++;
    xfer_byte(1'b0, 8'h3C, 8, 1'b0, rx);
    n_checks++;
    if (rx !== 8'hA5) $display("FAIL basic_master_rx: got %h want a5", rx); else n_pass++;
    ss_end();
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, do0} !== {1'b1, exp}) $display("FAIL basic_spi_do: got %b/%h want 1/%h", rxv0, do0, exp); else n_pass++;
    n_checks++;
    if ({busy0, oe0, miso0} !== 3'b001) $display("FAIL basic_idle_pins: got %b want 001", {busy0, oe0, miso0}); else n_pass++;
    cpu_read();
    n_checks++;
    if (rxv0 !== 1'b0) $display("FAIL basic_rd_clear: got %b want 0", rxv0); else n_pass++;
  endtask

  task automatic test_idle_byte();
    logic [7:0] rx, exp;
    rx_q.push_back(8'h12);
    ss_begin();
    xfer_byte(1'b0, 8'h12, 8, 1'b0, rx);
    n_checks++;
    if (rx !== 8'hFF) $display("FAIL idle_master_rx: got %h want ff", rx); else n_pass++;
    ss_end();
    exp = rx_q.pop_front();
    n_checks++;
    if (do0 !== exp) $display("FAIL idle_spi_do: got %h want %h", do0, exp); else n_pass++;
    cpu_read();
  endtask

  task automatic test_overrun();
    logic [7:0] rx, exp;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    ss_begin();
    xfer_byte(1'b0, 8'h11, 8, 1'b0, rx);
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, ovr0, do0} !== {2'b10, exp}) $display("FAIL ovr_first: got %b%b/%h want 10/%h", rxv0, ovr0, do0, exp); else n_pass++;
    xfer_byte(1'b0, 8'h22, 8, 1'b0, rx);
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, ovr0, do0} !== {2'b11, exp}) $display("FAIL ovr_second: got %b%b/%h want 11/%h", rxv0, ovr0, do0, exp); else n_pass++;
    ss_end();
    cpu_read();
    n_checks++;
    if ({rxv0, ovr0} !== 2'b00) $display("FAIL ovr_rd_clear: got %b want 00", {rxv0, ovr0}); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] rx, exp;
    cpu_write(8'h96);
    ss_begin();
    xfer_byte(1'b0, 8'hF0, 4, 1'b0, rx);
    n_checks++;
    if (rx[3:0] !== 4'h9) $display("FAIL abort_partial_rx: got %h want 9", rx[3:0]); else n_pass++;
    ss_end();
    n_checks++;
    if ({rxv0, busy0, miso0, txe0} !== 4'b0011) $display("FAIL abort_state: got %b want 0011", {rxv0, busy0, miso0, txe0}); else n_pass++;
    cpu_write(8'h69);
    rx_q.push_back(8'h5A);
    ss_begin();
    xfer_byte(1'b0, 8'h5A, 8, 1'b0, rx);
    n_checks++;
    if (rx !== 8'h69) $display("FAIL abort_next_master_rx: got %h want 69", rx); else n_pass++;
    ss_end();
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, do0} !== {1'b1, exp}) $display("FAIL abort_next_spi_do: got %b/%h want 1/%h", rxv0, do0, exp); else n_pass++;
    cpu_read();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx, exp;
    rx_q.push_back(8'h33);
    rx_q.push_back(8'hCC);
    ss_begin();
    xfer_byte(1'b0, 8'h33, 8, 1'b0, rx);
    exp = rx_q.pop_front();
    n_checks++;
    if (do0 !== exp) $display("FAIL b2b_first: got %h want %h", do0, exp); else n_pass++;
    xfer_byte(1'b0, 8'hCC, 8, 1'b1, rx);
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, ovr0, do0} !== {2'b10, exp}) $display("FAIL b2b_rd_collide: got %b%b/%h want 10/%h", rxv0, ovr0, do0, exp); else n_pass++;
    ss_end();
    cpu_read();
  endtask

  task automatic test_phase1();
    logic [7:0] rx, exp;
    cpu_write(8'hC3);
    rx_q.push_back(8'hC3);
    ss_begin();
    xfer_byte(1'b1, 8'hC3, 8, 1'b0, rx);
    n_checks++;
    if (rx !== 8'hC3) $display("FAIL ph1_master_rx: got %h want c3", rx); else n_pass++;
    ss_end();
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv1, do1} !== {1'b1, exp}) $display("FAIL ph1_spi_do: got %b/%h want 1/%h", rxv1, do1, exp); else n_pass++;
    cpu_read();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, exp;
    cpu_write(8'hE7);
    ss_begin();
    xfer_byte(1'b0, 8'hAA, 5, 1'b0, rx);
    n_checks++;
    if (busy0 !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy0); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({do0, rxv0, ovr0, txe0, busy0, miso0, oe0} !== {8'h00, 6'b001010})
      $display("FAIL rstmid_async_dut0: got %h want %h", {do0, rxv0, ovr0, txe0, busy0, miso0, oe0}, {8'h00, 6'b001010});
    else n_pass++;
    spi_ss = 1'b1;
    spi_sck = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    cpu_write(8'h81);
    rx_q.push_back(8'h7E);
    ss_begin();
    xfer_byte(1'b0, 8'h7E, 8, 1'b0, rx);
    n_checks++;
    if (rx !== 8'h81) $display("FAIL rstmid_next_master_rx: got %h want 81", rx); else n_pass++;
    ss_end();
    exp = rx_q.pop_front();
    n_checks++;
    if ({rxv0, ovr0, do0} !== {2'b10, exp}) $display("FAIL rstmid_next_spi_do: got %b%b/%h want 10/%h", rxv0, ovr0, do0, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_byte();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_phase1();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI responder (slave) core. It lets an external SPI master clock bytes into and out of the SoC; it is the counterpart of the flash-facing spicore master. It sits on the CPU memory bus as a memory-mapped device: a transmit holding register, a receive data register and status flags. All SPI inputs are oversampled in the system clock domain; there is no second clock.

Parameters:
POLARITY, 1, CPOL: idle level of spi_sck
PHASE, 0, CPHA: 0 = sample on leading edge, 1 = sample on trailing edge
IDLE_BYTE, 8'hFF, byte shifted out when no transmit byte is held

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
we  input  1  write strobe: load spi_di into the transmit holding register
spi_di  input  8  transmit byte from CPU
rd  input  1  read acknowledge: clears rx_valid and overrun
spi_do  output  8  last completed received byte
rx_valid  output  1  spi_do holds an unread byte
overrun  output  1  sticky: a byte completed while rx_valid was set
tx_empty  output  1  transmit holding register free
busy  output  1  synchronised spi_ss is active (low)
spi_sck  input  1  master clock, asynchronous to clk
spi_ss  input  1  master select, active low
spi_mosi  input  1  master data in
spi_miso  output  1  data to master
spi_miso_oe  output  1  tristate enable for spi_miso, equal to busy

Behaviour:
- Reset values: spi_do = 0, rx_valid = 0, overrun = 0, tx_empty = 1, busy = 0, spi_miso = 1, spi_miso_oe = 0, bit counter = 0, transmit holding = 0.
- spi_sck, spi_ss and spi_mosi each pass through a 2-flop synchroniser followed by an edge detector.
- An input edge is acted on 3 clk cycles after the pin changes.
- Supported range: f(spi_sck) <= f(clk)/8.
- Leading edge: spi_sck goes from POLARITY to ~POLARITY. Trailing edge: the reverse.
- States: IDLE (ss high) and SHIFT (ss low). ss falling moves IDLE to SHIFT. ss rising returns to IDLE from any bit position.
- Byte load happens on ss falling and on each byte completion:
  - Shift register loads the holding register if tx_empty = 0, otherwise IDLE_BYTE.
  - tx_empty is set to 1 when the holding register is consumed.
- PHASE = 0:
  - spi_miso = bit 7 immediately on load.
  - Sample spi_mosi on each leading edge; shift out the next bit on each trailing edge.
  - A byte completes on the 8th leading edge, and the reload happens in that same cycle.
- PHASE = 1:
  - On each leading edge, drive the next bit onto spi_miso; the first leading edge after a load drives bit 7.
  - Sample spi_mosi on each trailing edge; a byte completes on the 8th trailing edge.
- Bit order is MSB first. The 3-bit bit counter wraps 7 -> 0 at byte completion.
- Byte completion: spi_do <= shifted byte and rx_valid <= 1.
  - If rx_valid was already 1 and rd is not asserted in the same cycle, overrun <= 1.
  - If rd and completion coincide, rx_valid stays 1 with the new data and overrun is unchanged.
- rd alone: rx_valid <= 0 and overrun <= 0.
- we: holding <= spi_di and tx_empty <= 0. While full, the latest write wins.
  - If we coincides with a load, the load takes the old content (or IDLE_BYTE if empty).
  - The newly written byte stays held and tx_empty = 0.
- ss rising mid-byte: the partial byte is discarded, rx_valid is unchanged, the bit counter is cleared, and spi_miso returns to 1.
  - A byte already loaded into the shift register counts as consumed.
- Edges on spi_sck while ss is high are ignored.
- reset asserted mid-byte forces every reset value immediately, asynchronously, including IDLE state.

Decomposition:
- Shared package spi_pkg:
  - constants for the leading/trailing edge selection per (POLARITY, PHASE);
  - default IDLE_BYTE;
  - status bit positions {overrun, busy, tx_empty, rx_valid} for the toplevel read mux.
- One sub-module, spi_sync_edge: 2-flop synchroniser plus rise/fall detect, with asynchronous reset to a parameterised idle level. It is instantiated three times.

Test Plan:
1. POLARITY = 1, PHASE = 0; we with 0xA5; master sends 0x3C at clk/8.
   - Master captures 0xA5; spi_do = 0x3C; rx_valid = 1; tx_empty = 1 after ss falls.
2. No we before the transfer; master sends 0x12.
   - Master captures 0xFF; spi_do = 0x12.
3. Two bytes 0x11, 0x22 in one ss-low period with no rd.
   - spi_do = 0x22, rx_valid = 1, overrun = 1; rd then clears both.
4. ss rises after 4 bits, then a full byte 0x5A.
   - No rx_valid pulse from the partial byte; spi_do = 0x5A; bit alignment is correct.
5. rd asserted in the exact cycle the second byte completes.
   - rx_valid = 1, overrun = 0, spi_do = new byte.
6. PHASE = 1 build, 0xC3 both directions; separately, reset pulsed at bit 5.
   - PHASE = 1: both sides receive 0xC3.
   - Reset at bit 5: all outputs at reset values; the next byte is received correctly.
